ps2_key_matrix: RTL and testbench



---
 rtl/ps2_key_matrix.sv | 119 +++++++++++
 tb/tb_ps2_key_matrix.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: translates toggle-flagged PS/2 events into a wired-AND
// keyboard matrix through a writable scancode map RAM. Events pass through
// three stages: detect and map read, apply to the key state, then the
// registered row lookup.
module ps2_key_matrix #(
  parameter int    COLS     = 8,
  parameter int    ROWS     = 8,
  parameter int    COL_W    = $clog2(COLS),
  parameter int    ROW_W    = $clog2(ROWS),
  parameter string MAP_INIT = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  input  logic [COL_W-1:0]         col,
  output logic [ROWS-1:0]          row_n,
  output logic                     nmi,
  output logic                     any_key,
  input  logic                     clear_all,
  input  logic                     map_we,
  input  logic [8:0]               map_addr,
  input  logic [2+COL_W+ROW_W-1:0] map_data
);

  localparam int MAP_W = 2 + COL_W + ROW_W;

  // Map entry layout, MSB first: {valid, is_nmi, col, row}.
  // Entries start out all zero, i.e. invalid.
  logic [MAP_W-1:0] map_mem [512] = '{default: '0};

  logic                      tog_q;
  logic                      pend_q;
  logic                      press_q;
  logic [MAP_W-1:0]          ent_q;
  logic [COLS-1:0][ROWS-1:0] state_q, state_d;
  logic                      nmi_q, nmi_d;
  logic [ROWS-1:0]           row_n_q;
  logic                      any_q;
  logic                      event_det;

  logic                      ent_valid;
  logic                      ent_nmi;
  logic [COL_W-1:0]          ent_col;
  logic [ROW_W-1:0]          ent_row;

  // A change of the toggle bit relative to its last sampled value is an event.
  assign event_det = ps2_key[10] ^ tog_q;

  // Detect stage: track the toggle, flag a pending event and latch its polarity.
  // Reset resamples the toggle so releasing reset never fakes an event.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      pend_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      pend_q <= event_det;
      if (event_det) begin
        press_q <= ps2_key[9];
      end
    end
  end

  // Map RAM: read-first single-port behaviour, lookup address is the raw code.
  always_ff @(posedge clk) begin
    if (map_we) begin
      map_mem[map_addr] <= map_data;
    end
    ent_q <= map_mem[ps2_key[8:0]];
  end

  assign ent_valid = ent_q[MAP_W-1];
  assign ent_nmi   = ent_q[MAP_W-2];
  assign ent_col   = ent_q[ROW_W +: COL_W];
  assign ent_row   = ent_q[0 +: ROW_W];

  // Apply stage: clear_all wins over any event; invalid or out-of-range entries drop.
  always_comb begin
    state_d = state_q;
    nmi_d   = nmi_q;
    if (clear_all) begin
      state_d = '0;
      nmi_d   = 1'b0;
    end else if (pend_q && ent_valid) begin
      if (ent_nmi) begin
        nmi_d = press_q;
      end else if ((int'(ent_col) < COLS) && (int'(ent_row) < ROWS)) begin
        state_d[ent_col][ent_row] = press_q;
      end
    end
  end

  // Key state and NMI registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      nmi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nmi_q   <= nmi_d;
    end
  end

  // Registered row read-back for the selected column plus the any-key summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_n_q <= '1;
      any_q   <= 1'b0;
    end else begin
      row_n_q <= (int'(col) < COLS) ? ~state_q[col] : '1;
      any_q   <= |state_q;
    end
  end

  assign row_n   = row_n_q;
  assign nmi     = nmi_q;
  assign any_key = any_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Testbench for ps2_key_matrix: directed scenarios plus randomized events
// checked against a simple key/NMI model driven by the map contents.
module tb_ps2_key_matrix;

  localparam int COLS = 8;
  localparam int ROWS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [2:0]  col;
  logic [7:0]  row_n;
  logic        nmi;
  logic        any_key;
  logic        clear_all;
  logic        map_we;
  logic [8:0]  map_addr;
  logic [7:0]  map_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: map contents, key matrix, NMI level.
  logic [7:0] map_m [512];
  bit         key_m [COLS][ROWS];
  bit         nmi_m;

  always #5 clk = ~clk;

  ps2_key_matrix #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .col      (col),
    .row_n    (row_n),
    .nmi      (nmi),
    .any_key  (any_key),
    .clear_all(clear_all),
    .map_we   (map_we),
    .map_addr (map_addr),
    .map_data (map_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        key_m[c][r] = 1'b0;
    nmi_m = 1'b0;
  endtask

  // Model applies an event immediately using the current map entry.
  task automatic model_event(input bit p, input logic [8:0] code);
    logic [7:0] e;
    e = map_m[code];
    if (e[7]) begin
      if (e[6]) nmi_m = p;
      else      key_m[e[5:3]][e[2:0]] = p;
    end
  endtask

  // Flip the toggle bit with a new press/code; the caller provides the edges.
  task automatic send(input bit p, input logic [8:0] code);
    ps2_key = {~ps2_key[10], p, code};
    model_event(p, code);
  endtask

  task automatic map_write(input logic [8:0] a, input logic [7:0] d);
    map_we   = 1'b1;
    map_addr = a;
    map_data = d;
    tick();
    map_we   = 1'b0;
    map_m[a] = d;
  endtask

  function automatic logic [7:0] model_row(input int c);
    logic [7:0] v;
    for (int r = 0; r < ROWS; r++) v[r] = ~key_m[c][r];
    return v;
  endfunction

  function automatic bit model_any();
    bit a;
    a = 1'b0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        a = a | key_m[c][r];
    return a;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (row_n !== 8'hFF) begin
      failures++;
      $display("FAIL reset_row_n: got %h expected %h", row_n, 8'hFF);
    end
    checks++;
    if (any_key !== 1'b0) begin
      failures++;
      $display("FAIL reset_any_key: got %b expected 0", any_key);
    end
    checks++;
    if (nmi !== 1'b0) begin
      failures++;
      $display("FAIL reset_nmi: got %b expected 0", nmi);
    end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_key();
    col = 3'd6;
    map_write(9'h01C, 8'hB5);  // {1,0,6,5}
    send(1'b1, 9'h01C);
    tick();  // edge N
    tick();  // edge N+1
    checks++;
    if (row_n !== 8'hFF) begin
      failures++;
      $display("FAIL single_early: got %h expected %h", row_n, 8'hFF);
    end
    tick();  // edge N+2
    checks++;
    if (row_n !== 8'b1101_1111) begin
      failures++;
      $display("FAIL single_press: got %h expected %h", row_n, 8'hDF);
    end
    checks++;
    if (any_key !== 1'b1) begin
      failures++;
      $display("FAIL single_any: got %b expected 1", any_key);
    end
    send(1'b0, 9'h01C);
    repeat (3) tick();
    checks++;
    if (row_n !== 8'hFF) begin
      failures++;
      $display("FAIL single_release: got %h expected %h", row_n, 8'hFF);
    end
    checks++;
    if (any_key !== 1'b0) begin
      failures++;
      $display("FAIL single_release_any: got %b expected 0", any_key);
    end
    $display("test_single_key done");
  endtask

  task automatic test_multi_key();
    map_write(9'h020, 8'h97);  // (2,7)
    map_write(9'h021, 8'h94);  // (2,4)
    map_write(9'h022, 8'h90);  // (2,0)
    col = 3'd2;
    send(1'b1, 9'h020); tick();
    send(1'b1, 9'h021); tick();
    send(1'b1, 9'h022); tick();
    repeat (2) tick();
    checks++;
    if (row_n !== 8'b0110_1110) begin
      failures++;
      $display("FAIL multi_col2: got %h expected %h", row_n, 8'h6E);
    end
    col = 3'd3;
    tick();
    checks++;
    if (row_n !== 8'hFF) begin
      failures++;
      $display("FAIL multi_col3: got %h expected %h", row_n, 8'hFF);
    end
    send(1'b0, 9'h020); tick();
    send(1'b0, 9'h021); tick();
    send(1'b0, 9'h022); tick();
    repeat (2) tick();
    checks++;
    if (any_key !== 1'b0) begin
      failures++;
      $display("FAIL multi_release_any: got %b expected 0", any_key);
    end
    $display("test_multi_key done");
  endtask

  task automatic test_nmi();
    map_write(9'h009, 8'hC0);  // {1,1,0,0}
    col = 3'd0;
    send(1'b1, 9'h009);
    tick();  // edge N
    checks++;
    if (nmi !== 1'b0) begin
      failures++;
      $display("FAIL nmi_early: got %b expected 0", nmi);
    end
    tick();  // edge N+1
    checks++;
    if (nmi !== 1'b1) begin
      failures++;
      $display("FAIL nmi_press: got %b expected 1", nmi);
    end
    tick();
    checks++;
    if (row_n !== 8'hFF || any_key !== 1'b0) begin
      failures++;
      $display("FAIL nmi_matrix: got row_n=%h any=%b expected row_n=ff any=0", row_n, any_key);
    end
    send(1'b0, 9'h009);
    repeat (2) tick();
    checks++;
    if (nmi !== 1'b0) begin
      failures++;
      $display("FAIL nmi_release: got %b expected 0", nmi);
    end
    map_write(9'h0AA, 8'h00);
    send(1'b1, 9'h0AA);
    repeat (3) tick();
    checks++;
    if (nmi !== 1'b0 || any_key !== 1'b0) begin
      failures++;
      $display("FAIL invalid_entry: got nmi=%b any=%b expected nmi=0 any=0", nmi, any_key);
    end
    $display("test_nmi done");
  endtask

  task automatic test_back_to_back();
    map_write(9'h030, 8'h89);  // A (1,1)
    map_write(9'h031, 8'hA2);  // B (4,2)
    map_write(9'h032, 8'hBE);  // C (7,6)
    send(1'b1, 9'h030); tick();
    send(1'b1, 9'h031); tick();
    send(1'b0, 9'h030); tick();
    send(1'b1, 9'h032); tick();
    repeat (2) tick();
    for (int c = 0; c < COLS; c++) begin
      col = 3'(c);
      tick();
      checks++;
      if (row_n !== model_row(c)) begin
        failures++;
        $display("FAIL b2b_col%0d: got %h expected %h", c, row_n, model_row(c));
      end
    end
    checks++;
    if (row_n !== 8'hBF || any_key !== 1'b1) begin
      failures++;
      $display("FAIL b2b_col7_fixed: got row_n=%h any=%b expected row_n=bf any=1", row_n, any_key);
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model_clear();
    tick();
    checks++;
    if (any_key !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clear_any: got %b expected 0", any_key);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++)
      map_write(9'h100 + 9'(k), 8'($urandom_range(0, 255)));
    for (int round = 0; round < 6; round++) begin
      for (int e = 0; e < 10; e++) begin
        send(1'($urandom_range(0, 1)), 9'h100 + 9'($urandom_range(0, 15)));
        tick();
        repeat ($urandom_range(0, 1)) tick();
      end
      repeat (3) tick();
      for (int c = 0; c < COLS; c++) begin
        col = 3'(c);
        tick();
        checks++;
        if (row_n !== model_row(c)) begin
          failures++;
          $display("FAIL rand_r%0d_col%0d: got %h expected %h", round, c, row_n, model_row(c));
        end
      end
      checks++;
      if (nmi !== nmi_m || any_key !== model_any()) begin
        failures++;
        $display("FAIL rand_r%0d_flags: got nmi=%b any=%b expected nmi=%b any=%b",
                 round, nmi, any_key, nmi_m, model_any());
      end
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model_clear();
    tick();
    $display("test_random done");
  endtask

  task automatic test_clear_collision();
    map_write(9'h040, 8'h9B);  // (3,3)
    col = 3'd3;
    send(1'b1, 9'h040);
    tick();              // detect
    clear_all = 1'b1;
    tick();              // apply and clear on the same edge
    clear_all = 1'b0;
    model_clear();
    repeat (2) tick();
    checks++;
    if (row_n !== 8'hFF || any_key !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_apply: got row_n=%h any=%b expected row_n=ff any=0", row_n, any_key);
    end
    // clear on the detect edge must not lose the event
    send(1'b1, 9'h040);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    repeat (3) tick();
    checks++;
    if (row_n !== 8'hF7) begin
      failures++;
      $display("FAIL clear_vs_detect: got %h expected %h", row_n, 8'hF7);
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model_clear();
    tick();
    $display("test_clear_collision done");
  endtask

  task automatic test_map_collision();
    map_write(9'h050, 8'hA9);  // old entry (5,1)
    col = 3'd5;
    map_we   = 1'b1;
    map_addr = 9'h050;
    map_data = 8'hAA;          // new entry (5,2)
    send(1'b1, 9'h050);        // model uses the old entry
    tick();
    map_we = 1'b0;
    map_m[9'h050] = 8'hAA;
    repeat (3) tick();
    checks++;
    if (row_n !== 8'hFD) begin
      failures++;
      $display("FAIL map_same_cycle: got %h expected %h", row_n, 8'hFD);
    end
    send(1'b0, 9'h050); tick();
    send(1'b1, 9'h050); tick();
    repeat (2) tick();
    checks++;
    if (row_n !== 8'hF9 || row_n !== model_row(5)) begin
      failures++;
      $display("FAIL map_next_event: got %h expected %h", row_n, 8'hF9);
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model_clear();
    tick();
    $display("test_map_collision done");
  endtask

  task automatic test_reset_mid_event();
    map_write(9'h060, 8'hB6);  // (6,6)
    col = 3'd6;
    send(1'b1, 9'h060);
    tick();                    // edge N: detect
    reset = 1'b1;
    tick();                    // edge N+1: reset
    reset = 1'b0;
    model_clear();
    repeat (3) tick();
    checks++;
    if (row_n !== 8'hFF || any_key !== 1'b0 || nmi !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_key: got row_n=%h any=%b nmi=%b expected ff/0/0", row_n, any_key, nmi);
    end
    send(1'b1, 9'h009);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    repeat (2) tick();
    checks++;
    if (nmi !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_nmi: got %b expected 0", nmi);
    end
    reset = 1'b1;
    tick();
    ps2_key = {1'b0, 1'b1, 9'h060};
    tick();
    ps2_key = {1'b1, 1'b1, 9'h060};
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (row_n !== 8'hFF || any_key !== 1'b0) begin
      failures++;
      $display("FAIL reset_toggle_held: got row_n=%h any=%b expected ff/0", row_n, any_key);
    end
    $display("test_reset_mid_event done");
  endtask

  initial begin
    reset     = 1'b1;
    ps2_key   = '0;
    col       = '0;
    clear_all = 1'b0;
    map_we    = 1'b0;
    map_addr  = '0;
    map_data  = '0;
    for (int a = 0; a < 512; a++) map_m[a] = 8'h00;
    model_clear();

    test_reset();
    test_single_key();
    test_multi_key();
    test_nmi();
    test_back_to_back();
    test_random();
    test_clear_collision();
    test_map_collision();
    test_reset_mid_event();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
